// File: rtl/filter_arbiter.sv
// filter_arbiter: round-robin reader over per-filter neighbour buffers.
// Optional FILTER_ARBITER_STATS_EN adds stall_cycles / grant_count.
package filter_arbiter_pkg;
  typedef struct packed {
    logic [7:0]  cell_id;
    logic [15:0] z;
    logic [15:0] y;
    logic [15:0] x;
  } position_data_t;
endpackage

module filter_arbiter
  import filter_arbiter_pkg::*;
#(
  parameter int NUM_FILTER = 8,
  parameter int RD_LATENCY = 1,
  parameter int SKID_DEPTH = 4,
  parameter int DRAIN_WAIT = 4,
  localparam int SW = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            src_done,
  input  logic [NUM_FILTER-1:0]           filter_empty,
  input  position_data_t [NUM_FILTER-1:0] filter_rd_data,
  output logic [NUM_FILTER-1:0]           filter_rd_en,
  input  logic                            out_ready,
  output logic                            out_valid,
  output position_data_t                  out_data,
  output logic [SW-1:0]                   out_sel,
  output logic                            done
`ifdef FILTER_ARBITER_STATS_EN
  ,
  output logic [31:0]                     stall_cycles,
  output logic [NUM_FILTER-1:0][15:0]     grant_count
`endif
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int IW = $clog2(RD_LATENCY + 1);
  localparam int DW = (DRAIN_WAIT > 0) ? $clog2(DRAIN_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [DW-1:0]       wcnt_q;
  logic                done_q;
  logic [SW-1:0]       rr_q;
  logic [RD_LATENCY-1:0] valid_q;
  logic [SW-1:0]       sel_q [RD_LATENCY];

  position_data_t      mem_q [SKID_DEPTH];
  logic [SW-1:0]       msel_q [SKID_DEPTH];
  logic [PW-1:0]       wr_q;
  logic [PW-1:0]       rd_q;
  logic [CW-1:0]       cnt_q;

  logic [SW-1:0]       cand;
  logic [SW-1:0]       gnt_idx;
  logic                gnt_ok;
  logic [IW-1:0]       in_flight;
  logic                room;
  logic                rd_act;
  logic                issue;
  logic                push;
  logic                pop;
  logic [SW-1:0]       push_sel;
  position_data_t      push_data;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // first non-empty buffer at or after the round-robin pointer
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_FILTER; k++) begin
      cand = SW'((int'(rr_q) + k) % NUM_FILTER);
      if (!gnt_ok && !filter_empty[cand]) begin
        gnt_ok  = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign in_flight = IW'($countones(valid_q));
  assign room = (int'(cnt_q) + int'(in_flight) + 1)
                <= SKID_DEPTH;
  assign rd_act = (state_q == S_RUN) ||
                  (state_q == S_WAIT) ||
                  (state_q == S_DRAIN);
  assign issue = rd_act && gnt_ok && room;
  assign filter_rd_en = issue
    ? (NUM_FILTER'(1) << gnt_idx) : '0;

  assign push      = valid_q[RD_LATENCY-1];
  assign push_sel  = sel_q[RD_LATENCY-1];
  assign push_data = filter_rd_data[push_sel];

  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign out_sel   = out_valid ? msel_q[rd_q] : '0;
  assign pop       = out_valid && out_ready;
  assign done      = done_q;

  // phase control: run, settle after src_done, drain, done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_RUN;
        end
        S_RUN: begin
          if (src_done) begin
            state_q <= S_WAIT;
            wcnt_q  <= DW'(DRAIN_WAIT);
          end
        end
        S_WAIT: begin
          if (wcnt_q == '0) state_q <= S_DRAIN;
          else wcnt_q <= wcnt_q - 1'b1;
        end
        S_DRAIN: begin
          if (&filter_empty && in_flight == '0 &&
              cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // pointer advance and read-latency tracking of the source index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q    <= '0;
      valid_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) sel_q[i] <= '0;
    end else begin
      if (issue)
        rr_q <= (gnt_idx == SW'(NUM_FILTER - 1))
                ? '0 : gnt_idx + 1'b1;
      valid_q[0] <= issue;
      sel_q[0]   <= gnt_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        sel_q[i]   <= sel_q[i-1];
      end
    end
  end

  // skid FIFO absorbing returning reads while downstream stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i]  <= '0;
        msel_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_q]  <= push_data;
        msel_q[wr_q] <= push_sel;
        wr_q         <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      if (push && !pop) cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef FILTER_ARBITER_STATS_EN
  logic [31:0]                 stall_q;
  logic [NUM_FILTER-1:0][15:0] gc_q;

  // stall and per-buffer grant counters, cleared per phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      gc_q    <= '0;
    end else if (start) begin
      stall_q <= '0;
      gc_q    <= '0;
    end else begin
      if (out_valid && !out_ready) stall_q <= stall_q + 1'b1;
      for (int i = 0; i < NUM_FILTER; i++)
        if (filter_rd_en[i] && gc_q[i] != 16'hFFFF)
          gc_q[i] <= gc_q[i] + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign grant_count  = gc_q;
`endif

endmodule

// File: tb/tb_filter_arbiter.sv
// tb_filter_arbiter: directed + randomized bench for filter_arbiter
// with queue-based buffer model and in-order scoreboard.
module tb_filter_arbiter;
  import filter_arbiter_pkg::*;

  localparam int NF    = 8;
  localparam int RDL   = 1;
  localparam int SD    = 4;
  localparam int DWAIT = 4;
  localparam int SW    = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic src_done;
  logic out_ready;
  logic out_valid;
  logic done;
  logic [NF-1:0] filter_empty = '1;
  logic [NF-1:0] filter_rd_en;
  position_data_t [NF-1:0] filter_rd_data = '0;
  position_data_t out_data;
  logic [SW-1:0] out_sel;
`ifdef FILTER_ARBITER_STATS_EN
  logic [31:0] stall_cycles;
  logic [NF-1:0][15:0] grant_count;
`endif

  always #5 clk = ~clk;

  filter_arbiter #(
    .NUM_FILTER(NF),
    .RD_LATENCY(RDL),
    .SKID_DEPTH(SD),
    .DRAIN_WAIT(DWAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .src_done(src_done),
    .filter_empty(filter_empty),
    .filter_rd_data(filter_rd_data),
    .filter_rd_en(filter_rd_en),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sel(out_sel),
    .done(done)
`ifdef FILTER_ARBITER_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .grant_count(grant_count)
`endif
  );

  typedef struct {
    position_data_t d;
    logic [SW-1:0]  s;
    int             t;
  } exp_t;

  position_data_t srcq [NF][$];
  exp_t expq[$];
  logic [NF-1:0] snap_rd = '0;
  logic [NF-1:0] er;
  bit ev;
  bit ref_run = 0;
  int cyc = 0;
  int ref_out = 0;
  int ref_rr = 0;
  int n_issue = 0;
  int n_pop = 0;
  int last_pop_cyc = 0;
  int ref_stall = 0;
  int ref_gc [NF];
  int serial = 0;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_src_empty();
    for (int i = 0; i < NF; i++)
      if (srcq[i].size() != 0) return 0;
    return 1;
  endfunction

  // reference: grant choice, latency, ordering, stall/grant counts
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      expq.delete();
      ref_out = 0;
      ref_rr  = 0;
      snap_rd = '0;
      ref_stall = 0;
      for (int i = 0; i < NF; i++) ref_gc[i] = 0;
    end else begin
      er = '0;
      if (ref_run && ref_out + 1 <= SD)
        for (int k = 0; k < NF; k++)
          if (er == '0 && srcq[(ref_rr + k) % NF].size() > 0)
            er[(ref_rr + k) % NF] = 1'b1;
      chk("rd_en", filter_rd_en, er);
      ev = expq.size() > 0 && expq[0].t + RDL + 1 <= cyc;
      chk("out_valid", out_valid, ev);
      if (ev) begin
        chk("out_sel", out_sel, expq[0].s);
        chk("out_data", out_data, expq[0].d);
      end
      if (start) begin
        ref_stall = 0;
        for (int i = 0; i < NF; i++) ref_gc[i] = 0;
      end else if (ev && !out_ready) begin
        ref_stall++;
      end
      if (ev && out_ready) begin
        void'(expq.pop_front());
        n_pop++;
        last_pop_cyc = cyc;
        ref_out--;
      end
      for (int i = 0; i < NF; i++)
        if (er[i]) begin
          expq.push_back('{d: srcq[i][0], s: SW'(i), t: cyc});
          ref_out++;
          ref_rr = (i + 1) % NF;
          n_issue++;
          ref_gc[i]++;
        end
      snap_rd = er;
    end
  end

  // buffer model: one-cycle read data, empty flags from queues
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NF; i++)
      if (snap_rd[i]) begin
        filter_rd_data[i] = srcq[i][0];
        void'(srcq[i].pop_front());
      end
    snap_rd = '0;
    for (int i = 0; i < NF; i++)
      filter_empty[i] = (srcq[i].size() == 0);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input int b, input int n);
    position_data_t e;
    for (int k = 0; k < n; k++) begin
      serial++;
      e.cell_id = 8'(serial);
      e.z = 16'(b);
      e.y = 16'($urandom);
      e.x = 16'(serial);
      srcq[b].push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    ref_run = 1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !(expq.size() == 0 && all_src_empty())) begin
      step();
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, tl, nv, p0, i0, cd, pushed, b;
    logic [7:0] g [$];
    logic [SW-1:0] os [$];
    position_data_t hold;
    rst = 1'b0;
    start = 1'b0;
    src_done = 1'b0;
    out_ready = 1'b0;
    step(3);
    chk("rst_rd_en", filter_rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    fill(0, 2);
    step(6);
    chk("idle_rd_en", filter_rd_en, 0);
    chk("idle_valid", out_valid, 0);

    // round-robin between buffers 0 and 2
    out_ready = 1'b1;
    fill(0, 4);
    fill(2, 6);
    pulse_start();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (filter_rd_en != 0 && g.size() < 4) g.push_back(filter_rd_en);
      if (out_valid && out_ready && os.size() < 4) os.push_back(out_sel);
    end
    chk("rr_cnt", g.size(), 4);
    chk("rr_g0", g[0], 8'h01);
    chk("rr_g1", g[1], 8'h04);
    chk("rr_g2", g[2], 8'h01);
    chk("rr_g3", g[3], 8'h04);
    chk("rr_s0", os[0], 0);
    chk("rr_s1", os[1], 2);
    chk("rr_s2", os[2], 0);
    chk("rr_s3", os[3], 2);
    step();
    wait_drain("rr_drain", 100);

    // single buffer burst and latency
    fill(3, 5);
    t0 = -1; t1 = -1; tl = -1; nv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (t0 < 0 && filter_rd_en != 0) t0 = c;
      if (out_valid) begin
        if (t1 < 0) t1 = c;
        tl = c;
        nv++;
        chk("burst_sel", out_sel, 3);
      end
    end
    chk("burst_lat", t1 - t0, RDL + 1);
    chk("burst_n", nv, 5);
    chk("burst_contig", tl - t1 + 1, 5);
    step();

    // back-pressure with 20 queued entries
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      b = $urandom_range(0, 2);
      fill(b == 0 ? 1 : (b == 1 ? 4 : 6), 1);
    end
    i0 = n_issue;
    p0 = n_pop;
    step(15);
    chk("bp_issues", n_issue - i0, SD);
    hold = out_data;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_stable", out_data, hold);
      chk("bp_rd_zero", filter_rd_en, 0);
    end
`ifdef FILTER_ARBITER_STATS_EN
    chk("bp_stall", stall_cycles, ref_stall);
`endif
    out_ready = 1'b1;
    wait_drain("bp_drain", 100);
    chk("bp_delivered", n_pop - p0, 20);

    // randomized traffic with random back-pressure
    p0 = n_pop;
    pushed = serial;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0)
        fill($urandom_range(0, NF - 1), $urandom_range(1, 3));
      step();
    end
    out_ready = 1'b1;
    wait_drain("rnd_drain", 1000);
    chk("rnd_delivered", n_pop - p0, serial - pushed);
`ifdef FILTER_ARBITER_STATS_EN
    for (int i = 0; i < NF; i++)
      chk("rnd_gcnt", grant_count[i], ref_gc[i]);
`endif

    // finish first phase
    src_done = 1'b1;
    cd = 0;
    for (int k = 0; k < 100 && cd == 0; k++) begin
      step();
      if (done) cd = k + 1;
    end
    chk("done1", done, 1);
    ref_run = 0;
    src_done = 1'b0;

    // phase end: 7 stalls, src_done, write during WAIT
    pulse_start();
    chk("done_clr", done, 0);
    fill(5, 3);
    fill(7, 3);
    p0 = n_pop;
    step(3);
    out_ready = 1'b0;
    step(7);
    out_ready = 1'b1;
    src_done = 1'b1;
    cd = 0;
    for (int k = 1; k <= 100 && cd == 0; k++) begin
      step();
      if (k == 2) fill(1, 1);
      if (done) begin
        cd = k;
        chk("done_after_pop", last_pop_cyc < cyc, 1);
      end
    end
    chk("done_seen", cd > 0, 1);
    chk("done_after_wait", cd >= DWAIT + 1, 1);
    chk("phase_pops", n_pop - p0, 7);
`ifdef FILTER_ARBITER_STATS_EN
    chk("stall7", stall_cycles, 7);
    for (int i = 0; i < NF; i++)
      chk("phase_gcnt", grant_count[i], ref_gc[i]);
`endif
    ref_run = 0;
    src_done = 1'b0;
    step(3);
    chk("done_hold", done, 1);

    // reset with entries in flight
    pulse_start();
    out_ready = 1'b0;
    fill(2, 5);
    fill(6, 5);
    i0 = n_issue;
    step(3);
    rst = 1'b0;
    ref_run = 0;
    #1;
    chk("mrst_rd_en", filter_rd_en, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_sel", out_sel, 0);
    chk("mrst_done", done, 0);
    chk("mrst_inflight", n_issue - i0, 3);
`ifdef FILTER_ARBITER_STATS_EN
    chk("mrst_stall", stall_cycles, 0);
`endif
    step(2);
    rst = 1'b1;
    step(5);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_rd", filter_rd_en, 0);
    p0 = n_pop;
    out_ready = 1'b1;
    pulse_start();
    wait_drain("post_rst_drain", 100);
    chk("post_rst_count", n_pop - p0, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
